mmio_gpio: RTL and testbench

Parametrised memory-mapped GPIO peripheral. It is the successor to the single-register switch reader. It provides four word-addressed registers:
- a synchronised, optionally debounced input port
- a read/write output port that drives the LEDs
- a write-1-to-clear change-status register
- an interrupt mask

It sits on the core's data-memory bus beside data RAM, decoded by the top-level address decoder.

---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_debounce.sv | 59 +++++
 rtl/mmio_gpio.sv | 104 ++++++++++
 tb/tb_mmio_gpio.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the mmio_gpio peripheral: bus data width and
// the word-offset register map decoded from memAddress[1:0].
package gpio_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    REG_IN     = 2'd0,
    REG_OUT    = 2'd1,
    REG_STATUS = 2'd2,
    REG_MASK   = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input conditioner: SYNC_STAGES-deep synchroniser, followed by a
// per-bit stability counter when GPIO_DEBOUNCE_EN is defined (direct otherwise).
module gpio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // Counter only runs while the input disagrees; it clears on agreement or on toggle.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (synced != db_q) begin
      if (cnt_q == CNT_LAST) db_d  = ~db_q;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign dout = db_q;
`else
  assign dout = synced;
`endif

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: IN / OUT / STATUS (W1C) / MASK registers with level irq.
// Define GPIO_DEBOUNCE_EN to insert per-bit debounce counters on the input path.
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned IN_W            = 16,
  parameter int unsigned OUT_W           = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [29:0]       memAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEnable,
  input  logic              readEnable,
  input  logic [IN_W-1:0]   switches,
  output logic [DATA_W-1:0] readData,
  output logic              readValid,
  output logic [OUT_W-1:0]  leds,
  output logic              irq
);

  reg_sel_e            sel;
  logic [IN_W-1:0]     db;
  logic [IN_W-1:0]     db_prev_q, db_prev_d;
  logic [IN_W-1:0]     status_q, status_d;
  logic [IN_W-1:0]     mask_q, mask_d;
  logic [IN_W-1:0]     w1c;
  logic [OUT_W-1:0]    out_q, out_d;
  logic [DATA_W-1:0]   sel_val;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                unused_bits;

  assign sel         = reg_sel_e'(memAddress[1:0]);
  assign unused_bits = ^{memAddress[29:2], writeData};

  for (genvar g = 0; g < IN_W; g++) begin : g_in
    gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk (clk),
      .rst (rst),
      .din (switches[g]),
      .dout(db[g])
    );
  end

  always_comb begin
    out_d     = out_q;
    mask_d    = mask_q;
    w1c       = '0;
    db_prev_d = db;
    if (writeEnable) begin
      unique case (sel)
        REG_OUT:    out_d  = writeData[OUT_W-1:0];
        REG_STATUS: w1c    = writeData[IN_W-1:0];
        REG_MASK:   mask_d = writeData[IN_W-1:0];
        default:    ;
      endcase
    end
    // A fresh edge is ORed in after the clear so a colliding set survives.
    status_d = (status_q & ~w1c) | (db ^ db_prev_q);
  end

  always_comb begin
    sel_val = '0;
    unique case (sel)
      REG_IN:     sel_val[IN_W-1:0]  = db;
      REG_OUT:    sel_val[OUT_W-1:0] = out_q;
      REG_STATUS: sel_val[IN_W-1:0]  = status_q;
      REG_MASK:   sel_val[IN_W-1:0]  = mask_q;
      default:    ;
    endcase
    rdata_d  = readEnable ? sel_val : rdata_q;
    rvalid_d = readEnable;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_prev_q <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      out_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      db_prev_q <= db_prev_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      out_q     <= out_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign readData  = rdata_q;
  assign readValid = rvalid_q;
  assign leds      = out_q;
  assign irq       = |(status_q & mask_q);

endmodule

// File: tb/tb_mmio_gpio.sv
// Self-checking bench for mmio_gpio: directed steps plus a random phase, all
// outputs compared every cycle against a register-level reference model.
module tb_mmio_gpio;

  localparam int S = 2;
  localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] memAddress;
  logic [31:0] writeData;
  logic        writeEnable;
  logic        readEnable;
  logic [15:0] switches;
  logic [31:0] readData;
  logic        readValid;
  logic [15:0] leds;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_gpio #(
    .IN_W           (16),
    .OUT_W          (16),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memAddress (memAddress),
    .writeData  (writeData),
    .writeEnable(writeEnable),
    .readEnable (readEnable),
    .switches   (switches),
    .readData   (readData),
    .readValid  (readValid),
    .leds       (leds),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: samp[k] holds switches sampled k+1 edges ago.
  logic [15:0] samp [S];
  logic [15:0] m_db, m_dbp, m_out, m_mask, m_status;
  int          m_run [16];
  logic [31:0] m_rdata;
  logic        m_rvalid;

  always @(posedge clk or negedge rst) begin
    logic [31:0] rv;
    logic [15:0] w1c, nxt_db, syn;
    if (!rst) begin
      for (int k = 0; k < S; k++) samp[k] <= '0;
      for (int i = 0; i < 16; i++) m_run[i] <= 0;
      m_db <= '0; m_dbp <= '0; m_out <= '0; m_mask <= '0; m_status <= '0;
      m_rdata <= '0; m_rvalid <= 1'b0;
    end else begin
      case (memAddress[1:0])
        2'd0:    rv = {16'h0, m_db};
        2'd1:    rv = {16'h0, m_out};
        2'd2:    rv = {16'h0, m_status};
        default: rv = {16'h0, m_mask};
      endcase
      if (readEnable) m_rdata <= rv;
      m_rvalid <= readEnable;
      w1c = '0;
      if (writeEnable) begin
        if (memAddress[1:0] == 2'd1) m_out  <= writeData[15:0];
        if (memAddress[1:0] == 2'd2) w1c    = writeData[15:0];
        if (memAddress[1:0] == 2'd3) m_mask <= writeData[15:0];
      end
      m_status <= (m_status & ~w1c) | (m_db ^ m_dbp);
      nxt_db = m_db;
      if (DEB) begin
        syn = samp[S-1];
        for (int i = 0; i < 16; i++) begin
          if (syn[i] != m_db[i]) begin
            if (m_run[i] + 1 == D) begin
              nxt_db[i] = ~m_db[i];
              m_run[i] <= 0;
            end else begin
              m_run[i] <= m_run[i] + 1;
            end
          end else begin
            m_run[i] <= 0;
          end
        end
      end else begin
        nxt_db = samp[S-2];
      end
      m_dbp <= m_db;
      m_db  <= nxt_db;
      samp[0] <= switches;
      for (int k = 1; k < S; k++) samp[k] <= samp[k-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("leds", 32'(leds), 32'(m_out));
    chk("irq", 32'(irq), 32'(|(m_status & m_mask)));
    chk("readValid", 32'(readValid), 32'(m_rvalid));
    chk("readData", readData, m_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic bus(input logic we, input logic re, input logic [1:0] a, input logic [31:0] d);
    writeEnable = we;
    readEnable  = re;
    memAddress  = {28'h0, a};
    writeData   = d;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    switches = 16'hFFFF;
    idle();
    // Reset with inputs high
    #3;
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_readData", readData, 32'h0);
    chk("rst_readValid", 32'(readValid), 32'h0);
    steps(3);
    rst = 1'b1;
    bus(1'b0, 1'b1, 2'd0, 32'h0);
    step();
    chk("in_early_zero", readData, 32'h0);
    for (int i = 0; i < 12; i++) step();
    chk("in_ffff", readData, 32'h0000FFFF);
    bus(1'b1, 1'b0, 2'd2, 32'hFFFF);
    step();

    // OUT write then read
    bus(1'b1, 1'b0, 2'd1, 32'hDEADBEEF);
    step();
    chk("leds_beef", 32'(leds), 32'h0000BEEF);
    bus(1'b0, 1'b1, 2'd1, 32'h0);
    step();
    chk("out_read", readData, 32'h0000BEEF);
    chk("out_readValid", 32'(readValid), 32'h1);
    idle();
    step();
    chk("readValid_drop", 32'(readValid), 32'h0);
    chk("readData_hold", readData, 32'h0000BEEF);

    // Short glitch on bit 0 (rejected only when debounced)
    bus(1'b1, 1'b0, 2'd2, 32'hFFFF);
    step();
    idle();
    switches[0] = 1'b0;
    steps(3);
    switches[0] = 1'b1;
    steps(10);
    bus(1'b0, 1'b1, 2'd2, 32'h0);
    step();
    chk("pulse_status", 32'(readData[0]), DEB ? 32'h0 : 32'h1);
    bus(1'b1, 1'b0, 2'd2, 32'hFFFF);
    step();
    idle();
    switches[0] = 1'b0;
    steps(10);
    bus(1'b0, 1'b1, 2'd0, 32'h0);
    step();
    chk("hold_in_bit0", 32'(readData[0]), 32'h0);
    bus(1'b0, 1'b1, 2'd2, 32'h0);
    step();
    chk("hold_status_bit0", 32'(readData[0]), 32'h1);

    // Interrupt masking
    bus(1'b1, 1'b0, 2'd2, 32'hFFFF);
    step();
    bus(1'b1, 1'b0, 2'd3, 32'h1);
    step();
    idle();
    switches[0] = 1'b1;
    steps(12);
    chk("irq_set", 32'(irq), 32'h1);
    bus(1'b1, 1'b0, 2'd2, 32'h1);
    step();
    chk("irq_clear", 32'(irq), 32'h0);
    bus(1'b1, 1'b0, 2'd3, 32'h0);
    step();
    idle();
    switches[0] = 1'b0;
    steps(12);
    chk("irq_masked", 32'(irq), 32'h0);
    bus(1'b0, 1'b1, 2'd2, 32'h0);
    step();
    chk("masked_status", 32'(readData[0]), 32'h1);

    // W1C on bit 3 in the same cycle its change lands
    bus(1'b1, 1'b0, 2'd2, 32'hFFFF);
    step();
    idle();
    switches[3] = ~switches[3];
    for (int i = 0; i < 20; i++) begin
      if (((m_db ^ m_dbp) & 16'h0008) != 16'h0) bus(1'b1, 1'b0, 2'd2, 32'h8);
      else idle();
      step();
    end
    bus(1'b0, 1'b1, 2'd2, 32'h0);
    step();
    chk("w1c_collision", 32'(readData[3]), 32'h1);
    bus(1'b1, 1'b0, 2'd2, 32'h8);
    step();
    bus(1'b0, 1'b1, 2'd2, 32'h0);
    step();
    chk("w1c_clear", 32'(readData[3]), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
          2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 5) == 0) switches[$urandom_range(0, 15)] ^= 1'b1;
      step();
    end

    // Reset mid-debounce with irq pending
    bus(1'b1, 1'b0, 2'd3, 32'hFFFF);
    step();
    idle();
    switches ^= 16'h0F00;
    steps(10);
    chk("irq_pending", 32'(irq), 32'h1);
    switches ^= 16'h00F0;
    steps(2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_leds", 32'(leds), 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_readData", readData, 32'h0);
    chk("async_readValid", 32'(readValid), 32'h0);
    steps(2);
    rst = 1'b1;
    bus(1'b0, 1'b1, 2'd2, 32'h0);
    step();
    chk("no_stale_status", readData, 32'h0);
    bus(1'b0, 1'b1, 2'd0, 32'h0);
    steps(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
